// File: rtl/deadtime_gen_pkg.sv
// ============================================================================
//  Module      : deadtime_gen_pkg
//  Description : Shared leg state encodings and default timing constants.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package deadtime_gen_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAD_TO_U = 3'd1,
        U_ON      = 3'd2,
        DEAD_TO_L = 3'd3,
        L_ON      = 3'd4
    } leg_state_t;

    localparam int c_DT_CYCLES = 100;
    localparam int c_CW        = 8;

endpackage

`default_nettype wire

// File: rtl/deadtime_gen_if.sv
// ============================================================================
//  Module      : deadtime_gen_if
//  Description : Raw modulator gate commands and dead-time gate-drive outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface deadtime_gen_if;

    logic Sau, Sal, Sbu, Sbl, Scu, Scl;
    logic Gau, Gal, Gbu, Gbl, Gcu, Gcl;

    modport master (
        output Sau, Sal, Sbu, Sbl, Scu, Scl,
        input  Gau, Gal, Gbu, Gbl, Gcu, Gcl
    );

    modport slave (
        input  Sau, Sal, Sbu, Sbl, Scu, Scl,
        output Gau, Gal, Gbu, Gbl, Gcu, Gcl
    );

endinterface

`default_nettype wire

// File: rtl/deadtime_gen_leg.sv
// ============================================================================
//  Module      : deadtime_gen_leg
//  Description : One inverter leg: input deglitch register, dead-time FSM,
//                counter and sticky shoot-through flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module deadtime_gen_leg
    import deadtime_gen_pkg::*;
#(
    parameter int DT_CYCLES = c_DT_CYCLES,
    parameter int CW        = c_CW
) (
    input  logic clk,
    input  logic res,
    input  logic i_kill,
    input  logic i_raw_u,
    input  logic i_raw_l,
    output logic o_gu,
    output logic o_gl,
    output logic o_st_err
);

    localparam logic [CW-1:0] c_DT_LOAD = CW'(DT_CYCLES - 1);

    logic            r_u, r_l;
    leg_state_t      r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_st_err, w_st_err_nxt;
    logic            r_gu, r_gl;
    logic            w_cmd_u, w_cmd_l, w_inv;

    assign w_cmd_u = r_u & ~r_l;
    assign w_cmd_l = ~r_u & r_l;
    assign w_inv   = ~(r_u ^ r_l);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_st_err_nxt = r_st_err;
        if (i_kill) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_inv) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            if (r_u) w_st_err_nxt = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_u) begin
                        w_state_nxt = DEAD_TO_U;
                        w_cnt_nxt   = c_DT_LOAD;
                    end else if (w_cmd_l) begin
                        w_state_nxt = DEAD_TO_L;
                        w_cnt_nxt   = c_DT_LOAD;
                    end
                end
                U_ON: begin
                    if (w_cmd_l) begin
                        w_state_nxt = DEAD_TO_L;
                        w_cnt_nxt   = c_DT_LOAD;
                    end
                end
                L_ON: begin
                    if (w_cmd_u) begin
                        w_state_nxt = DEAD_TO_U;
                        w_cnt_nxt   = c_DT_LOAD;
                    end
                end
                // An abort during dead time goes straight back: the incoming switch never conducted.
                DEAD_TO_U: begin
                    if (w_cmd_l)              w_state_nxt = L_ON;
                    else if (r_cnt == '0)     w_state_nxt = U_ON;
                    else                      w_cnt_nxt   = r_cnt - CW'(1);
                end
                DEAD_TO_L: begin
                    if (w_cmd_u)              w_state_nxt = U_ON;
                    else if (r_cnt == '0)     w_state_nxt = L_ON;
                    else                      w_cnt_nxt   = r_cnt - CW'(1);
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Gate outputs come straight from flops so the pins never see decode glitches.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_u      <= 1'b0;
            r_l      <= 1'b0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_st_err <= 1'b0;
            r_gu     <= 1'b0;
            r_gl     <= 1'b0;
        end else begin
            r_u      <= i_raw_u;
            r_l      <= i_raw_l;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_st_err <= w_st_err_nxt;
            r_gu     <= (w_state_nxt == U_ON);
            r_gl     <= (w_state_nxt == L_ON);
        end
    end

    assign o_gu     = r_gu;
    assign o_gl     = r_gl;
    assign o_st_err = r_st_err;

endmodule

`default_nettype wire

// File: rtl/deadtime_gen.sv
// ============================================================================
//  Module      : deadtime_gen
//  Description : Three-leg dead-time inserter with enable gate and latched trip.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module deadtime_gen
    import deadtime_gen_pkg::*;
#(
    parameter int DT_CYCLES = c_DT_CYCLES,
    parameter int CW        = c_CW
) (
    input  logic           clk,
    input  logic           res,
    input  logic           en,
    input  logic           fault,
    input  logic           clr_fault,
    deadtime_gen_if.slave  bus,
    output logic           fault_latched,
    output logic [2:0]     st_err
);

    logic       r_fault_latched;
    logic       w_kill;
    logic [2:0] w_su, w_sl, w_gu, w_gl;

    // A set request wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res)             r_fault_latched <= 1'b0;
        else if (fault)      r_fault_latched <= 1'b1;
        else if (clr_fault)  r_fault_latched <= 1'b0;
    end

    assign w_kill        = ~en | r_fault_latched | fault;
    assign fault_latched = r_fault_latched;

    assign w_su = {bus.Scu, bus.Sbu, bus.Sau};
    assign w_sl = {bus.Scl, bus.Sbl, bus.Sal};

    assign bus.Gau = w_gu[0];
    assign bus.Gal = w_gl[0];
    assign bus.Gbu = w_gu[1];
    assign bus.Gbl = w_gl[1];
    assign bus.Gcu = w_gu[2];
    assign bus.Gcl = w_gl[2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_leg
            deadtime_gen_leg #(
                .DT_CYCLES (DT_CYCLES),
                .CW        (CW)
            ) u_leg (
                .clk      (clk),
                .res      (res),
                .i_kill   (w_kill),
                .i_raw_u  (w_su[gi]),
                .i_raw_l  (w_sl[gi]),
                .o_gu     (w_gu[gi]),
                .o_gl     (w_gl[gi]),
                .o_st_err (st_err[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_deadtime_gen.sv
// ============================================================================
//  Module      : tb_deadtime_gen
//  Description : Directed vector table plus no-overlap / dead-gap monitors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_deadtime_gen;

    typedef struct {
        string      name;
        logic       en;
        logic       fault;
        logic       clr;
        logic [5:0] s;
        int         cyc;
        logic [5:0] g;
        logic       fl;
        logic [2:0] st;
    } vec_t;

    localparam int c_DT [3] = '{100, 1, 255};

    logic clk = 1'b0;
    logic res, en, fault, clr_fault;
    logic one = 1'b1;
    logic zero = 1'b0;
    logic       fl0, fl1, fl2;
    logic [2:0] st0, st1, st2;
    logic [2:0] up1, up2;
    logic [5:0] g0;
    logic [2:0] gu [3];
    logic [2:0] gl [3];
    bit         done = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       tbl[$];

    deadtime_gen_if bus0 ();
    deadtime_gen_if bus1 ();
    deadtime_gen_if bus2 ();

    deadtime_gen #(.DT_CYCLES(100), .CW(8)) u_dut (
        .clk(clk), .res(res), .en(en), .fault(fault), .clr_fault(clr_fault),
        .bus(bus0), .fault_latched(fl0), .st_err(st0));
    deadtime_gen #(.DT_CYCLES(1), .CW(8)) u_dt1 (
        .clk(clk), .res(res), .en(one), .fault(zero), .clr_fault(zero),
        .bus(bus1), .fault_latched(fl1), .st_err(st1));
    deadtime_gen #(.DT_CYCLES(255), .CW(8)) u_dt255 (
        .clk(clk), .res(res), .en(one), .fault(zero), .clr_fault(zero),
        .bus(bus2), .fault_latched(fl2), .st_err(st2));

    always #5 clk = ~clk;

    assign g0 = {bus0.Gau, bus0.Gal, bus0.Gbu, bus0.Gbl, bus0.Gcu, bus0.Gcl};
    assign gu[0] = {bus0.Gcu, bus0.Gbu, bus0.Gau};
    assign gl[0] = {bus0.Gcl, bus0.Gbl, bus0.Gal};
    assign gu[1] = {bus1.Gcu, bus1.Gbu, bus1.Gau};
    assign gl[1] = {bus1.Gcl, bus1.Gbl, bus1.Gal};
    assign gu[2] = {bus2.Gcu, bus2.Gbu, bus2.Gau};
    assign gl[2] = {bus2.Gcl, bus2.Gbl, bus2.Gal};

    // Random DUTs always see complementary commands.
    assign {bus1.Sau, bus1.Sal, bus1.Sbu, bus1.Sbl, bus1.Scu, bus1.Scl} =
           {up1[0], ~up1[0], up1[1], ~up1[1], up1[2], ~up1[2]};
    assign {bus2.Sau, bus2.Sal, bus2.Sbu, bus2.Sbl, bus2.Scu, bus2.Scl} =
           {up2[0], ~up2[0], up2[1], ~up2[1], up2[2], ~up2[2]};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic set_s(input logic [5:0] s);
        {bus0.Sau, bus0.Sal, bus0.Sbu, bus0.Sbl, bus0.Scu, bus0.Scl} = s;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input string n, input logic e, input logic f, input logic c,
                               input logic [5:0] s, input int cy, input logic [5:0] g,
                               input logic fl, input logic [2:0] st);
        vec_t r;
        r.name = n; r.en = e; r.fault = f; r.clr = c; r.s = s;
        r.cyc = cy; r.g = g; r.fl = fl; r.st = st;
        return r;
    endfunction

    initial begin
        up1 = 3'b000;
        while (!done) begin
            @(posedge clk);
            #2;
            up1 = 3'($urandom_range(0, 7));
        end
    end

    initial begin
        int hold [3];
        up2 = 3'b000;
        for (int i = 0; i < 3; i++) hold[i] = 1;
        while (!done) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    up2[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 600);
                end
            end
        end
    end

    // Per leg: never both on, and a switch-over to the opposite side waits DT.
    initial begin
        int   run  [3][3];
        int   last [3][3];
        int   side;
        logic u, l;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 3; i++) begin
                run[d][i]  = 0;
                last[d][i] = 0;
            end
        while (!done) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 3; i++) begin
                    u = gu[d][i];
                    l = gl[d][i];
                    n_cmp++;
                    if (u & l) begin
                        n_err++;
                        $display("FAIL overlap dut%0d leg%0d: gu=%b gl=%b, required not both 1", d, i, u, l);
                    end
                    if (u | l) begin
                        side = u ? 1 : 2;
                        if (run[d][i] > 0 && last[d][i] != 0 && last[d][i] != side) begin
                            n_cmp++;
                            if (run[d][i] < c_DT[d]) begin
                                n_err++;
                                $display("FAIL deadgap dut%0d leg%0d: gap %0d, required >= %0d",
                                         d, i, run[d][i], c_DT[d]);
                            end
                        end
                        run[d][i]  = 0;
                        last[d][i] = side;
                    end else begin
                        run[d][i]++;
                    end
                end
            end
        end
    end

    initial begin
        res = 1'b1; en = 1'b1; fault = 1'b0; clr_fault = 1'b0;
        set_s(6'b000000);
        clocks(3);
        chk("reset_g", 32'(g0), 32'h0);
        chk("reset_fl", 32'(fl0), 32'h0);
        chk("reset_st", 32'(st0), 32'h0);
        res = 1'b0;

        //                name         en    flt   clr   S          cyc  G          fl    st
        tbl.push_back(v("t1_wait",    1'b1, 1'b0, 1'b0, 6'b101001, 101, 6'b000000, 1'b0, 3'b000));
        tbl.push_back(v("t1_on",      1'b1, 1'b0, 1'b0, 6'b101001,   1, 6'b101001, 1'b0, 3'b000));
        tbl.push_back(v("t2_k",       1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b101001, 1'b0, 3'b000));
        tbl.push_back(v("t2_off",     1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b001001, 1'b0, 3'b000));
        tbl.push_back(v("t2_dead",    1'b1, 1'b0, 1'b0, 6'b011001,  99, 6'b001001, 1'b0, 3'b000));
        tbl.push_back(v("t2_on",      1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b011001, 1'b0, 3'b000));
        tbl.push_back(v("t3_pulse",   1'b1, 1'b0, 1'b0, 6'b101001,  30, 6'b001001, 1'b0, 3'b000));
        tbl.push_back(v("t3_back",    1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b001001, 1'b0, 3'b000));
        tbl.push_back(v("t3_ret",     1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b011001, 1'b0, 3'b000));
        tbl.push_back(v("t4_inv",     1'b1, 1'b0, 1'b0, 6'b011101,   1, 6'b011001, 1'b0, 3'b000));
        tbl.push_back(v("t4_kill",    1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b010001, 1'b0, 3'b010));
        tbl.push_back(v("t4_dead",    1'b1, 1'b0, 1'b0, 6'b011001, 100, 6'b010001, 1'b0, 3'b010));
        tbl.push_back(v("t4_on",      1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b011001, 1'b0, 3'b010));
        tbl.push_back(v("t5_trip",    1'b1, 1'b1, 1'b0, 6'b011001,   1, 6'b000000, 1'b1, 3'b010));
        tbl.push_back(v("t5_hold",    1'b1, 1'b0, 1'b0, 6'b011001,   5, 6'b000000, 1'b1, 3'b010));
        tbl.push_back(v("t5_clr_ign", 1'b1, 1'b1, 1'b1, 6'b011001,   1, 6'b000000, 1'b1, 3'b010));
        tbl.push_back(v("t5_wait",    1'b1, 1'b0, 1'b0, 6'b011001,   3, 6'b000000, 1'b1, 3'b010));
        tbl.push_back(v("t5_clr",     1'b1, 1'b0, 1'b1, 6'b011001,   1, 6'b000000, 1'b0, 3'b010));
        tbl.push_back(v("t5_dead",    1'b1, 1'b0, 1'b0, 6'b011001, 100, 6'b000000, 1'b0, 3'b010));
        tbl.push_back(v("t5_on",      1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b011001, 1'b0, 3'b010));
        tbl.push_back(v("en_off",     1'b0, 1'b0, 1'b0, 6'b011001,   1, 6'b000000, 1'b0, 3'b010));
        tbl.push_back(v("en_dead",    1'b1, 1'b0, 1'b0, 6'b011001, 100, 6'b000000, 1'b0, 3'b010));
        tbl.push_back(v("en_on",      1'b1, 1'b0, 1'b0, 6'b011001,   1, 6'b011001, 1'b0, 3'b010));

        foreach (tbl[i]) begin
            en = tbl[i].en; fault = tbl[i].fault; clr_fault = tbl[i].clr;
            set_s(tbl[i].s);
            clocks(tbl[i].cyc);
            chk({tbl[i].name, "_g"},  32'(g0),  32'(tbl[i].g));
            chk({tbl[i].name, "_fl"}, 32'(fl0), 32'(tbl[i].fl));
            chk({tbl[i].name, "_st"}, 32'(st0), 32'(tbl[i].st));
        end
        fault = 1'b0; clr_fault = 1'b0; en = 1'b1;

        // Asynchronous reset while legs are on: outputs drop before the next edge.
        #2 res = 1'b1;
        #1;
        chk("rst_on_g",  32'(g0),  32'h0);
        chk("rst_on_st", 32'(st0), 32'h0);
        @(posedge clk); #1 res = 1'b0;
        clocks(50);
        chk("rst_dead_pre_g", 32'(g0), 32'h0);
        #2 res = 1'b1;
        #1;
        chk("rst_dead_g", 32'(g0), 32'h0);
        @(posedge clk); #1 res = 1'b0;
        // Full dead time must apply again: nothing retained from before the reset.
        clocks(101);
        chk("rst_restart_dead_g", 32'(g0), 32'h0);
        clocks(1);
        chk("rst_restart_on_g", 32'(g0), 32'(6'b011001));
        chk("rst_restart_fl", 32'(fl0), 32'h0);

        clocks(20000);
        chk("rand_dt1_st",   32'(st1), 32'h0);
        chk("rand_dt1_fl",   32'(fl1), 32'h0);
        chk("rand_dt255_st", 32'(st2), 32'h0);
        chk("rand_dt255_fl", 32'(fl2), 32'h0);
        done = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
